// File: rtl/perf_snapshot_reader_if.sv
// Bus bundle for perf_snapshot_reader: the counter block's CSR read/write port
// plus the valid/ready snapshot stream toward the trace/debug consumer.
interface perf_snapshot_reader_if;
  logic [11:0] addr_o;
  logic        we_o;
  logic [63:0] wdata_o;
  logic [63:0] rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [4:0]  idx_o;
  logic        last_o;
  logic [63:0] sample_o;

  modport master (
    output addr_o, we_o, wdata_o,
    input  rdata_i,
    output valid_o, idx_o, last_o, sample_o,
    input  ready_i
  );

  modport slave (
    input  addr_o, we_o, wdata_o,
    output rdata_i,
    input  valid_o, idx_o, last_o, sample_o,
    output ready_i
  );
endinterface

// File: rtl/perf_snapshot_reader.sv
// Sweeps mhpmcounter3.. over the counter CSR port into a snapshot FIFO, periodically or on trigger.
// Define PERF_SNAPSHOT_CLEAR_EN to zero each counter after it is read (delta reporting).
module perf_snapshot_reader #(
  // Standalone defaults matching ariane_pkg::MHPMCounterNum
  parameter int unsigned NumCounters = 6,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned PeriodWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   trigger_i,
  input  logic                   clear_overrun_i,
  output logic                   busy_o,
  output logic [7:0]             overrun_o,
  perf_snapshot_reader_if.master bus
);

  localparam logic [11:0] CsrMhpmCounter3 = 12'hB03;  // riscv::CSR_MHPM_COUNTER_3
  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);
  localparam logic [4:0]  LastK = 5'(NumCounters - 1);

  typedef enum logic [1:0] {IDLE, READ, CLEAR} state_e;

  typedef struct packed {
    logic [4:0]  idx;
    logic        last;
    logic [63:0] value;
  } entry_t;

  state_e     state;
  logic [4:0] k;

  // ---------------- request generation ----------------
  logic [PeriodWidth-1:0] pcnt;
  logic                   period_active;
  logic                   tick;
  logic                   req;

  assign period_active = enable_i && (period_i != '0);
  assign tick          = period_active && (pcnt == '0);
  assign req           = trigger_i || tick;

  always_ff @(posedge clk_i) begin
    if (rst_i || !period_active) begin
      pcnt <= '0;
    end else if (pcnt == '0) begin
      pcnt <= period_i - PeriodWidth'(1);
    end else begin
      pcnt <= pcnt - PeriodWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_overrun_i) begin
      overrun_o <= '0;
    end else if (req && busy_o && (overrun_o != 8'hFF)) begin
      overrun_o <= overrun_o + 8'd1;
    end
  end

  // ---------------- snapshot FIFO ----------------
  entry_t          mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic            full, push, pop;
  entry_t          head;

  // NOTE: full comes from the registered count, so a pop in the same cycle cannot free room for a push.
  assign full = (count == CntW'(FifoDepth));
  assign push = (state == READ) && !full;
  assign pop  = bus.valid_o && bus.ready_i;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; count alone decides which entries are visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{idx: k, last: (k == LastK), value: bus.rdata_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign bus.valid_o  = (count != '0);
  assign bus.idx_o    = head.idx;
  assign bus.last_o   = head.last;
  assign bus.sample_o = head.value;
  assign bus.wdata_o  = '0;

  // ---------------- sweep FSM ----------------
`ifdef PERF_SNAPSHOT_CLEAR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      k          <= '0;
      busy_o     <= 1'b0;
      bus.addr_o <= '0;
      bus.we_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state      <= READ;
          k          <= '0;
          busy_o     <= 1'b1;
          bus.addr_o <= CsrMhpmCounter3;
        end
        READ: if (!full) begin
          state    <= CLEAR;
          bus.we_o <= 1'b1;
        end
        CLEAR: begin
          bus.we_o <= 1'b0;
          if (k == LastK) begin
            state      <= IDLE;
            k          <= '0;
            busy_o     <= 1'b0;
            bus.addr_o <= '0;
          end else begin
            state      <= READ;
            k          <= k + 5'd1;
            bus.addr_o <= CsrMhpmCounter3 + {7'd0, k + 5'd1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign bus.we_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      k          <= '0;
      busy_o     <= 1'b0;
      bus.addr_o <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state      <= READ;
          k          <= '0;
          busy_o     <= 1'b1;
          bus.addr_o <= CsrMhpmCounter3;
        end
        READ: if (!full) begin
          if (k == LastK) begin
            state      <= IDLE;
            k          <= '0;
            busy_o     <= 1'b0;
            bus.addr_o <= '0;
          end else begin
            k          <= k + 5'd1;
            bus.addr_o <= CsrMhpmCounter3 + {7'd0, k + 5'd1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_perf_snapshot_reader.sv
// Self-checking bench for perf_snapshot_reader: counter-port model, FIFO scoreboard,
// scenario tasks for sweep, stall, periodic, overrun, reset (and clear mode when built with it).
module tb_perf_snapshot_reader;
  localparam int N     = 6;
  localparam int DEPTH = 4;
  localparam logic [11:0] BASE = 12'hB03;
`ifdef PERF_SNAPSHOT_CLEAR_EN
  localparam int SWEEP = 2 * N;
`else
  localparam int SWEEP = N;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic        last;
    logic [63:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        clear_ov = 1'b0;
  logic [15:0] period = '0;
  logic        busy;
  logic [7:0]  overrun;

  perf_snapshot_reader_if bus ();

  perf_snapshot_reader #(
    .NumCounters (N),
    .FifoDepth   (DEPTH),
    .PeriodWidth (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .period_i        (period),
    .trigger_i       (trigger),
    .clear_overrun_i (clear_ov),
    .busy_o          (busy),
    .overrun_o       (overrun),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  // Counter block model: combinational read, write on we_o, bulk load from the bench.
  logic [63:0] cnt_val  [N];
  logic [63:0] load_val [N];
  logic        load_req = 1'b0;
  logic [11:0] off;
  logic        in_range;

  assign off         = bus.addr_o - BASE;
  assign in_range    = (bus.addr_o >= BASE) && (off < 12'(N));
  assign bus.rdata_i = in_range ? cnt_val[off[2:0]] : 64'd0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) cnt_val[i] <= load_val[i];
    end else if (bus.we_o && in_range) begin
      cnt_val[off[2:0]] <= bus.wdata_o;
    end
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard: every accepted FIFO entry is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_entry got idx=%0d last=%0d value=%0d", bus.idx_o, bus.last_o, bus.sample_o);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.idx_o, bus.last_o, bus.sample_o} !== mon_e) begin
          errors++;
          $display("FAIL entry got idx=%0d last=%0d value=%0d want idx=%0d last=%0d value=%0d",
                   bus.idx_o, bus.last_o, bus.sample_o, mon_e.idx, mon_e.last, mon_e.value);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load(input longint base, input longint inc);
    for (int i = 0; i < N; i++) load_val[i] = 64'(base + inc * i);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic expect_sweep();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.idx = 5'(i); e.last = (i == N - 1); e.value = cnt_val[i];
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !bus.valid_o && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if ({busy, bus.valid_o, bus.we_o, overrun} !== 11'd0) begin
      errors++;
      $display("FAIL reset_flags got busy=%0d valid=%0d we=%0d overrun=%0d want all 0", busy, bus.valid_o, bus.we_o, overrun);
    end
    checks++;
    if ({bus.addr_o, bus.wdata_o} !== 76'd0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0", bus.addr_o, bus.wdata_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_sweep();
    bit ok;
    load(10, 10);
    expect_sweep();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({busy, bus.we_o, bus.addr_o} !== {1'b1, 1'b0, BASE + 12'(k)}) begin
        errors++;
        $display("FAIL sweep_read%0d got busy=%0d we=%0d addr=%h want 1 0 %h", k, busy, bus.we_o, bus.addr_o, BASE + 12'(k));
      end
      step();
`ifdef PERF_SNAPSHOT_CLEAR_EN
      checks++;
      if ({bus.we_o, bus.addr_o, bus.wdata_o} !== {1'b1, BASE + 12'(k), 64'd0}) begin
        errors++;
        $display("FAIL sweep_clear%0d got we=%0d addr=%h wdata=%h want 1 %h 0", k, bus.we_o, bus.addr_o, bus.wdata_o, BASE + 12'(k));
      end
      step();
`endif
    end
    checks++;
    if ({busy, bus.addr_o} !== 13'd0) begin
      errors++;
      $display("FAIL sweep_end got busy=%0d addr=%h want 0 000", busy, bus.addr_o);
    end
    drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sweep_drain got pending=%0d want 0", sb.size());
    end
  endtask

`ifdef PERF_SNAPSHOT_CLEAR_EN
  task automatic test_clear_deltas();
    bit   ok;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt_val[i] !== 64'd0) begin
        errors++;
        $display("FAIL cleared%0d got %0d want 0", i, cnt_val[i]);
      end
      load_val[i] = cnt_val[i] + 64'(i + 1);
    end
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.idx = 5'(i); e.last = (i == N - 1); e.value = 64'(i + 1);
      sb.push_back(e);
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    drain(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL delta_drain got pending=%0d want 0", sb.size());
    end
  endtask
`endif

  task automatic test_stall();
    bit ok;
    bus.ready_i = 1'b0;
    load(100, 1);
    expect_sweep();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(3 * SWEEP);
    checks++;
    if ({busy, bus.valid_o, bus.addr_o, bus.idx_o} !== {1'b1, 1'b1, BASE + 12'(DEPTH), 5'd0}) begin
      errors++;
      $display("FAIL stall got busy=%0d valid=%0d addr=%h idx=%0d want 1 1 %h 0",
               busy, bus.valid_o, bus.addr_o, bus.idx_o, BASE + 12'(DEPTH));
    end
    bus.ready_i = 1'b1;
    drain(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_periodic();
    logic prev;
    bit   rose, want, ok, saw_busy;
    load(500, 7);
    period = 16'd100;
    enable = 1'b1;
    for (int c = 0; c < 350; c++) begin
      want = (c % 100 == 0);
      if (want) expect_sweep();
      prev = busy;
      step();
      rose = busy && !prev;
      checks++;
      if (rose !== want) begin
        errors++;
        $display("FAIL period_start cycle=%0d got start=%0d want %0d", c, rose, want);
      end
    end
    period = 16'd0;
    saw_busy = 1'b0;
    for (int c = 0; c < 250; c++) begin
      step();
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0) begin
      errors++;
      $display("FAIL period_zero got sweep=%0d want 0", saw_busy);
    end
    enable = 1'b0;
    drain(20, ok);
    checks++;
    if (!ok || overrun !== 8'd0) begin
      errors++;
      $display("FAIL period_drain got pending=%0d overrun=%0d want 0 0", sb.size(), overrun);
    end
  endtask

  task automatic test_coincide();
    period  = 16'd50;
    enable  = 1'b1;
    trigger = 1'b1;
    expect_sweep();
    step();
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL coincide_start got busy=%0d want 1", busy);
    end
    step(SWEEP + 2);
    checks++;
    if ({busy, overrun} !== 9'd0) begin
      errors++;
      $display("FAIL coincide_single got busy=%0d overrun=%0d want 0 0", busy, overrun);
    end
    enable = 1'b0;
    period = 16'd0;
    step(2);
  endtask

  task automatic test_overrun();
    bit ok;
    bus.ready_i = 1'b0;
    expect_sweep();
    trigger = 1'b1;
    step(4);
    trigger = 1'b0;
    checks++;
    if (overrun !== 8'd3) begin
      errors++;
      $display("FAIL overrun_count got %0d want 3", overrun);
    end
    trigger  = 1'b1;
    clear_ov = 1'b1;
    step();
    trigger  = 1'b0;
    clear_ov = 1'b0;
    checks++;
    if (overrun !== 8'd0) begin
      errors++;
      $display("FAIL overrun_clear_priority got %0d want 0", overrun);
    end
    trigger = 1'b1;
    step(260);
    trigger = 1'b0;
    checks++;
    if (overrun !== 8'd255) begin
      errors++;
      $display("FAIL overrun_saturate got %0d want 255", overrun);
    end
    clear_ov = 1'b1;
    step();
    clear_ov = 1'b0;
    bus.ready_i = 1'b1;
    drain(60, ok);
    checks++;
    if (!ok || overrun !== 8'd0) begin
      errors++;
      $display("FAIL overrun_drain got pending=%0d overrun=%0d want 0 0", sb.size(), overrun);
    end
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    expect_sweep();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(2);
    rst = 1'b1;
    sb.delete();
    step();
    checks++;
    if ({busy, bus.valid_o, bus.we_o, bus.addr_o} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid got busy=%0d valid=%0d we=%0d addr=%h want 0 0 0 000", busy, bus.valid_o, bus.we_o, bus.addr_o);
    end
    rst = 1'b0;
    bus.ready_i = 1'b1;
    step(3);
    checks++;
    if ({busy, bus.valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_discard got busy=%0d valid=%0d want 0 0", busy, bus.valid_o);
    end
  endtask

  initial begin
    bus.ready_i = 1'b1;
    test_reset();
    test_single_sweep();
`ifdef PERF_SNAPSHOT_CLEAR_EN
    test_clear_deltas();
`endif
    test_stall();
    test_periodic();
    test_coincide();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
